sync_fifo_param: RTL and testbench

- Parametrised synchronous FIFO. Next generation of the team's 8x16 FIFO memory unit.
- Adds the following to the fixed-size design:
  - configurable data width and depth
  - fill-level output
  - programmable almost-full / almost-empty thresholds
  - synchronous flush
  - write-through-on-full when a read is accepted in the same cycle
  - sticky overflow/underflow with explicit clear
  - read-data valid strobe
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ram_sdp.sv | 35 +++
 rtl/sync_fifo_param.sv | 118 +++++++++++
 tb/tb_sync_fifo_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers and status-vector indices for sync_fifo_param
package fifo_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FLAG_FULL      = 0;
  localparam int FLAG_EMPTY     = 1;
  localparam int FLAG_AFULL     = 2;
  localparam int FLAG_AEMPTY    = 3;
  localparam int FLAG_OVERFLOW  = 4;
  localparam int FLAG_UNDERFLOW = 5;
  localparam int FLAG_COUNT     = 6;

endpackage

// File: rtl/fifo_ram_sdp.sv
// rtl/fifo_ram_sdp.sv - simple dual-port RAM, one write port and one registered read port
module fifo_ram_sdp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register samples the old word on a same-address write, and holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with thresholds, flush and sticky errors
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              flush,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              ovf_clr,
  input  logic              udf_clr,
  output logic [ADDR_W:0]   level,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_afull,
  output logic              fifo_aempty,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      count;
  logic [FLAG_COUNT-1:0] status;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  rd_drop;
  logic                  ovf_q;
  logic                  udf_q;

  // Flush wins over both requests: nothing is accepted and nothing is counted as dropped.
  assign rd_acc  = rd & ~status[FLAG_EMPTY] & ~flush;
  assign wr_acc  = wr & (~status[FLAG_FULL] | rd_acc) & ~flush;
  assign wr_drop = wr & ~wr_acc & ~flush;
  assign rd_drop = rd & ~rd_acc & ~flush;

  assign count = wptr - rptr;

  assign status[FLAG_FULL]      = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                                  (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign status[FLAG_EMPTY]     = (wptr == rptr);
  assign status[FLAG_AFULL]     = (count >= af_thresh);
  assign status[FLAG_AEMPTY]    = (count <= ae_thresh);
  assign status[FLAG_OVERFLOW]  = ovf_q;
  assign status[FLAG_UNDERFLOW] = udf_q;

  assign level          = count;
  assign fifo_full      = status[FLAG_FULL];
  assign fifo_empty     = status[FLAG_EMPTY];
  assign fifo_afull     = status[FLAG_AFULL];
  assign fifo_aempty    = status[FLAG_AEMPTY];
  assign fifo_overflow  = status[FLAG_OVERFLOW];
  assign fifo_underflow = status[FLAG_UNDERFLOW];

  // Write and read pointers; the MSB is the wrap bit distinguishing full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_W'(1);
      if (rd_acc) rptr <= rptr + PTR_W'(1);
    end
  end

  // Read-valid strobe marks the cycle after an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

  // Sticky error flags; a new event beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_drop)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (rd_drop)      udf_q <= 1'b1;
      else if (udf_clr) udf_q <= 1'b0;
    end
  end

  fifo_ram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              flush;
  logic [ADDR_W:0]   af_thresh;
  logic [ADDR_W:0]   ae_thresh;
  logic              ovf_clr;
  logic              udf_clr;
  logic [ADDR_W:0]   level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_afull;
  logic              fifo_aempty;
  logic              fifo_overflow;
  logic              fifo_underflow;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_rv;
  logic              m_ovf;
  logic              m_udf;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr             (wr),
    .data_in        (data_in),
    .rd             (rd),
    .data_out       (data_out),
    .rd_valid       (rd_valid),
    .flush          (flush),
    .af_thresh      (af_thresh),
    .ae_thresh      (ae_thresh),
    .ovf_clr        (ovf_clr),
    .udf_clr        (udf_clr),
    .level          (level),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_afull     (fifo_afull),
    .fifo_aempty    (fifo_aempty),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    check({ctx, " level"},    32'(level), 32'(n));
    check({ctx, " full"},     32'(fifo_full), 32'(n == DEPTH));
    check({ctx, " empty"},    32'(fifo_empty), 32'(n == 0));
    check({ctx, " afull"},    32'(fifo_afull), 32'(n >= int'(af_thresh)));
    check({ctx, " aempty"},   32'(fifo_aempty), 32'(n <= int'(ae_thresh)));
    check({ctx, " rd_valid"}, 32'(rd_valid), 32'(m_rv));
    check({ctx, " data_out"}, 32'(data_out), 32'(m_dout));
    check({ctx, " overflow"}, 32'(fifo_overflow), 32'(m_ovf));
    check({ctx, " underflow"},32'(fifo_underflow), 32'(m_udf));
  endtask

  // One clock: apply inputs, advance the reference at the edge, compare just after it.
  task automatic cycle(input string ctx, input logic w, input logic [7:0] d, input logic r,
                       input logic f, input logic oc, input logic uc);
    bit was_full, was_empty, racc, wacc;
    wr = w; data_in = d; rd = r; flush = f; ovf_clr = oc; udf_clr = uc;
    @(posedge clk);
    if (f) begin
      q.delete();
      m_rv = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      racc = r && !was_empty;
      wacc = w && (!was_full || racc);
      if (racc) begin
        m_dout = q.pop_front();
        m_rv   = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (wacc) q.push_back(d);
      if (w && !wacc) m_ovf = 1'b1;
      else if (oc)    m_ovf = 1'b0;
      if (r && !racc) m_udf = 1'b1;
      else if (uc)    m_udf = 1'b0;
    end
    #1;
    check_all(ctx);
    wr = 0; rd = 0; flush = 0; ovf_clr = 0; udf_clr = 0;
  endtask

  initial begin
    rst_n = 1'b0; wr = 0; rd = 0; flush = 0; ovf_clr = 0; udf_clr = 0;
    data_in = '0; af_thresh = 5'd12; ae_thresh = 5'd3;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) cycle("fill", 1, 8'(i), 0, 0, 0, 0);
    cycle("ovf_write", 1, 8'h99, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) cycle("drain", 0, 8'h00, 1, 0, 0, 0);
    cycle("udf_read", 0, 8'h00, 1, 0, 0, 0);
    cycle("clr_both", 0, 8'h00, 0, 0, 1, 1);

    for (int i = 0; i < 16; i++) cycle("refill", 1, 8'($urandom), 0, 0, 0, 0);
    cycle("wr_rd_full", 1, 8'hAA, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle("drain_aa", 0, 8'h00, 1, 0, 0, 0);

    cycle("wr_rd_empty", 1, 8'h55, 1, 0, 0, 0);
    cycle("read_55", 0, 8'h00, 1, 0, 0, 1);

    for (int i = 0; i < 80; i++) begin
      if (q.size() < 3 && (i % 2 == 0)) cycle("wrap_w", 1, 8'($urandom), 0, 0, 0, 0);
      else if (q.size() > 0)            cycle("wrap_r", 0, 8'h00, 1, 0, 0, 0);
      else                              cycle("wrap_w", 1, 8'($urandom), 0, 0, 0, 0);
    end
    while (q.size() > 0) cycle("wrap_d", 0, 8'h00, 1, 0, 0, 0);

    for (int i = 0; i < 9; i++) cycle("to9", 1, 8'($urandom), 0, 0, 0, 0);
    cycle("flush_wr", 1, 8'h77, 0, 1, 0, 0);
    cycle("after_flush", 0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) cycle("ovf_fill", 1, 8'($urandom), 0, 0, 0, 0);
    cycle("ovf_clr", 0, 8'h00, 0, 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      logic w, r, f, oc, uc;
      if (i % 37 == 0) begin
        af_thresh = 5'($urandom_range(0, 20));
        ae_thresh = 5'($urandom_range(0, 20));
      end
      w  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35));
      r  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65));
      f  = ($urandom_range(0, 99) < 2);
      oc = !f && ($urandom_range(0, 99) < 10);
      uc = !f && ($urandom_range(0, 99) < 10);
      cycle("rand", w, 8'($urandom), r, f, oc, uc);
    end

    af_thresh = 5'd12; ae_thresh = 5'd3;
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 8'($urandom), 0, 0, 0, 0);
    cycle("pre_rst_rd", 1, 8'h00, 1, 0, 0, 0);
    cycle("pre_rst_ovf", 0, 8'h00, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1, 8'h3C, 0, 0, 0, 0);
    cycle("post_rst_rd", 0, 8'h00, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
